change_dispense_sequencer: RTL and testbench

Sequences the coin-return hopper after a vending transaction. It takes a change amount in cents from the vending controller and dispenses it greedily as quarters, dimes and nickels, one coin per four-phase handshake with the hopper. Empty coin tubes cause a fallback to smaller coins. It sits beside the vending controller and reports remaining change to the display path.

---
 rtl/vm_pkg.sv | 25 ++
 rtl/tick_timeout.sv | 30 +++
 rtl/change_dispense_sequencer.sv | 152 +++++++++++++++
 tb/tb_change_dispense_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// Coin values, coin_sel encoding and sequencer state encoding shared by the
// change dispense sequencer and its bench.
package vm_pkg;

   localparam int unsigned Q_VAL = 25;
   localparam int unsigned D_VAL = 10;
   localparam int unsigned N_VAL = 5;

   typedef enum logic [1:0] {
      COIN_NONE    = 2'b00,
      COIN_NICKEL  = 2'b01,
      COIN_DIME    = 2'b10,
      COIN_QUARTER = 2'b11
   } coin_e;

   typedef enum logic [2:0] {
      IDLE,
      SELECT,
      REQ,
      RELEASE,
      DONE,
      FAULT
   } state_e;

endpackage

// File: rtl/tick_timeout.sv
// Clear/enable tick counter with a terminal flag; bounds how long the hopper
// may take to move its acknowledge.
module tick_timeout #(
   parameter int unsigned LIMIT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int unsigned CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt_q;

   // Saturates at LIMIT so a long stall cannot wrap back below the threshold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i && !expired_o) begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

   assign expired_o = (cnt_q == CW'(LIMIT));

endmodule

// File: rtl/change_dispense_sequencer.sv
// Pays out change greedily (quarter, dime, nickel) over a four-phase hopper
// handshake, falling back to smaller coins when a tube is empty.
module change_dispense_sequencer
   import vm_pkg::*;
#(
   parameter int unsigned AMT_W       = 8,
   parameter int unsigned Q_VAL       = vm_pkg::Q_VAL,
   parameter int unsigned D_VAL       = vm_pkg::D_VAL,
   parameter int unsigned N_VAL       = vm_pkg::N_VAL,
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             clk_en,
   input  logic             start,
   input  logic [AMT_W-1:0] change_amt,
   input  logic [2:0]       tube_empty,
   input  logic             hopper_ack,
   input  logic             clear_fault,
   output logic             coin_req,
   output logic [1:0]       coin_sel,
   output logic [AMT_W-1:0] change_left,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam logic [AMT_W-1:0] Q_AMT = AMT_W'(Q_VAL);
   localparam logic [AMT_W-1:0] D_AMT = AMT_W'(D_VAL);
   localparam logic [AMT_W-1:0] N_AMT = AMT_W'(N_VAL);

   state_e           state_q, state_d;
   coin_e            sel_q, sel_d;
   logic [AMT_W-1:0] left_q, left_d;

   coin_e            pick;
   logic [AMT_W-1:0] sel_amt;
   logic             amt_bad;
   logic             tmo_clr;
   logic             tmo_en;
   logic             tmo_expired;

   // Amounts that are not whole nickels can never be paid out exactly.
   assign amt_bad = (change_amt % N_AMT) != '0;

   always_comb begin
      pick = COIN_NONE;
      if (!tube_empty[2] && left_q >= Q_AMT) begin
         pick = COIN_QUARTER;
      end else if (!tube_empty[1] && left_q >= D_AMT) begin
         pick = COIN_DIME;
      end else if (!tube_empty[0] && left_q >= N_AMT) begin
         pick = COIN_NICKEL;
      end
   end

   always_comb begin
      unique case (sel_q)
         COIN_QUARTER: sel_amt = Q_AMT;
         COIN_DIME:    sel_amt = D_AMT;
         COIN_NICKEL:  sel_amt = N_AMT;
         default:      sel_amt = '0;
      endcase
   end

   // NOTE: non-blocking assignments so every register updates from pre-edge values.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q <= IDLE;
         sel_q   <= COIN_NONE;
         left_q  <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         left_q  <= left_d;
      end
   end

   // NOTE: every output of this block is defaulted first so no path infers a latch.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      left_d  = left_q;
      tmo_clr = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               left_d  = change_amt;
               state_d = amt_bad ? FAULT : SELECT;
            end
         end
         SELECT: begin
            if (left_q == '0) begin
               state_d = DONE;
            end else if (pick != COIN_NONE) begin
               sel_d   = pick;
               tmo_clr = 1'b1;
               state_d = REQ;
            end else begin
               state_d = FAULT;
            end
         end
         REQ: begin
            if (hopper_ack) begin
               left_d  = left_q - sel_amt;
               tmo_clr = 1'b1;
               state_d = RELEASE;
            end else if (tmo_expired) begin
               state_d = FAULT;
            end
         end
         RELEASE: begin
            if (!hopper_ack) begin
               state_d = SELECT;
            end else if (tmo_expired) begin
               state_d = FAULT;
            end
         end
         DONE: begin
            sel_d   = COIN_NONE;
            state_d = IDLE;
         end
         FAULT: begin
            if (clear_fault) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign tmo_en = clk_en && (state_q == REQ || state_q == RELEASE);

   tick_timeout #(
      .LIMIT (ACK_TIMEOUT)
   ) u_ack_timeout (
      .clk       (clk),
      .rst_n     (clr_n),
      .clr_i     (tmo_clr),
      .en_i      (tmo_en),
      .expired_o (tmo_expired)
   );

   // Moore decode keeps coin_req glitch-free and lets reset drop it at once.
   assign coin_req    = (state_q == REQ);
   assign coin_sel    = (state_q == REQ) ? sel_q : COIN_NONE;
   assign change_left = left_q;
   assign busy        = (state_q != IDLE) && (state_q != FAULT);
   assign done        = (state_q == DONE);
   assign err         = (state_q == FAULT);

endmodule

// File: tb/tb_change_dispense_sequencer.sv
// Directed bench for change_dispense_sequencer: a transaction-level greedy
// change model checked every cycle, plus literal expectations per scenario.
module tb_change_dispense_sequencer;

   logic       clk         = 1'b0;
   logic       clr_n       = 1'b0;
   logic       clk_en      = 1'b0;
   logic       start       = 1'b0;
   logic [7:0] change_amt  = '0;
   logic [2:0] tube_empty  = '0;
   logic       hopper_ack  = 1'b0;
   logic       clear_fault = 1'b0;
   logic       coin_req;
   logic [1:0] coin_sel;
   logic [7:0] change_left;
   logic       busy;
   logic       done;
   logic       err;

   int total = 0;
   int bad   = 0;

   change_dispense_sequencer dut (
      .clk         (clk),
      .clr_n       (clr_n),
      .clk_en      (clk_en),
      .start       (start),
      .change_amt  (change_amt),
      .tube_empty  (tube_empty),
      .hopper_ack  (hopper_ack),
      .clear_fault (clear_fault),
      .coin_req    (coin_req),
      .coin_sel    (coin_sel),
      .change_left (change_left),
      .busy        (busy),
      .done        (done),
      .err         (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] greedy(input int unsigned amt, input logic [2:0] te);
      if (amt >= 25 && !te[2]) return 2'b11;
      if (amt >= 10 && !te[1]) return 2'b10;
      if (amt >= 5  && !te[0]) return 2'b01;
      return 2'b00;
   endfunction

   function automatic int unsigned coin_val(input logic [1:0] c);
      case (c)
         2'b11:   return 25;
         2'b10:   return 10;
         2'b01:   return 5;
         default: return 0;
      endcase
   endfunction

   // clk_en: one tick every fourth clock
   int div = 0;
   always @(posedge clk) begin
      #1;
      div    = (div + 1) % 4;
      clk_en = (div == 0);
   end

   // hopper: acks hop_delay cycles after coin_req rises, releases when it drops
   logic hop_en    = 1'b0;
   int   hop_delay = 3;
   int   hop_cnt   = 0;
   always @(posedge clk) begin
      #1;
      if (!hop_en || !coin_req) begin
         hopper_ack = 1'b0;
         hop_cnt    = 0;
      end else if (hop_cnt >= hop_delay) begin
         hopper_ack = 1'b1;
      end else begin
         hop_cnt++;
      end
   end

   // transaction-level model and per-cycle compare
   int unsigned m_rem    = 0;
   bit          m_active = 1'b0;
   bit          m_fault  = 1'b0;
   int          m_ticks  = 0;
   int          done_cnt = 0;
   logic        prev_req = 1'b0;
   logic [1:0]  coin_log[$];
   logic [7:0]  left_log[$];

   always @(negedge clk) begin
      if (!clr_n) begin
         m_rem    = 0;
         m_active = 1'b0;
         m_fault  = 1'b0;
         check("rst_coin_req", 32'(coin_req), 0);
         check("rst_coin_sel", 32'(coin_sel), 0);
         check("rst_change_left", 32'(change_left), 0);
         check("rst_busy_done_err", 32'({busy, done, err}), 0);
      end else begin
         check("change_left", 32'(change_left), m_rem);
         if (coin_req) begin
            check("coin_sel", 32'(coin_sel), 32'(greedy(m_rem, tube_empty)));
            if (!prev_req) begin
               coin_log.push_back(coin_sel);
               left_log.push_back(change_left);
               m_ticks = 0;
            end
            if (clk_en) m_ticks++;
         end else begin
            check("coin_sel_idle", 32'(coin_sel), 0);
         end
         if (!m_active) check("coin_req_outside_txn", 32'(coin_req), 0);
         check("busy_and_err", 32'(busy & err), 0);
         if (done) done_cnt++;

         if (clear_fault) begin
            m_active = 1'b0;
            m_fault  = 1'b0;
         end else if (!m_active && !m_fault && start) begin
            m_rem = change_amt;
            if ((m_rem % 5) != 0 || (m_rem != 0 && greedy(m_rem, tube_empty) == 2'b00))
               m_fault = 1'b1;
            else if (m_rem != 0)
               m_active = 1'b1;
         end else if (m_active && coin_req && hopper_ack) begin
            m_rem = m_rem - coin_val(greedy(m_rem, tube_empty));
            if (m_rem == 0) begin
               m_active = 1'b0;
            end else if (greedy(m_rem, tube_empty) == 2'b00) begin
               m_active = 1'b0;
               m_fault  = 1'b1;
            end
         end
      end
      prev_req = coin_req;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic [7:0] amt);
      change_amt = amt;
      start      = 1'b1;
      step(1);
      start      = 1'b0;
   endtask

   task automatic pulse_clear();
      clear_fault = 1'b1;
      step(1);
      clear_fault = 1'b0;
   endtask

   task automatic wait_done(input int want, input int budget);
      int n = 0;
      while (done_cnt < want && n < budget) begin
         step(1);
         n++;
      end
      check("done_count", 32'(done_cnt), 32'(want));
   endtask

   task automatic new_case();
      coin_log.delete();
      left_log.delete();
      done_cnt = 0;
   endtask

   initial begin
      int n;

      // reset state
      step(3);
      check("reset_change_left", 32'(change_left), 0);
      check("reset_err", 32'(err), 0);
      clr_n = 1'b1;
      step(2);

      // 40 cents, tubes full: quarter, dime, nickel
      new_case();
      hop_en = 1'b1;
      pulse_start(8'd40);
      check("t1_req_not_yet", 32'(coin_req), 0);
      step(1);
      check("t1_req_rise", 32'(coin_req), 1);
      check("t1_first_quarter", 32'(coin_sel), 3);
      wait_done(1, 200);
      check("t1_coins", 32'(coin_log.size()), 3);
      check("t1_c0", 32'(coin_log[0]), 3);
      check("t1_c1", 32'(coin_log[1]), 2);
      check("t1_c2", 32'(coin_log[2]), 1);
      check("t1_left0", 32'(left_log[0]), 40);
      check("t1_left1", 32'(left_log[1]), 15);
      check("t1_left2", 32'(left_log[2]), 5);
      step(1);
      check("t1_left_end", 32'(change_left), 0);
      check("t1_err", 32'(err), 0);
      check("t1_single_done", 32'(done_cnt), 1);

      // 30 cents, quarter tube empty: three dimes
      new_case();
      tube_empty = 3'b100;
      pulse_start(8'd30);
      wait_done(1, 200);
      check("t2_coins", 32'(coin_log.size()), 3);
      check("t2_c0", 32'(coin_log[0]), 2);
      check("t2_c1", 32'(coin_log[1]), 2);
      check("t2_c2", 32'(coin_log[2]), 2);
      step(2);

      // 15 cents, dime and nickel empty: fault without a request
      new_case();
      tube_empty = 3'b011;
      pulse_start(8'd15);
      step(2);
      check("t3_no_req", 32'(coin_log.size()), 0);
      check("t3_err", 32'(err), 1);
      check("t3_left", 32'(change_left), 15);
      check("t3_busy", 32'(busy), 0);
      pulse_start(8'd50);
      step(1);
      check("t3_start_ignored_left", 32'(change_left), 15);
      check("t3_start_ignored_err", 32'(err), 1);
      pulse_clear();
      check("t3_cleared_err", 32'(err), 0);
      check("t3_cleared_left", 32'(change_left), 15);
      tube_empty = 3'b000;
      step(1);

      // 25 cents, hopper silent: timeout after 255 clk_en ticks
      new_case();
      hop_en = 1'b0;
      pulse_start(8'd25);
      n = 0;
      while (!err && n < 2000) begin
         step(1);
         n++;
      end
      check("t4_fault", 32'(err), 1);
      check("t4_ticks", 32'(m_ticks), 255);
      check("t4_req_dropped", 32'(coin_req), 0);
      check("t4_left", 32'(change_left), 25);
      pulse_clear();
      check("t4_cleared", 32'(err), 0);

      // zero change: done two cycles after start
      new_case();
      pulse_start(8'd0);
      check("t5_busy", 32'(busy), 1);
      check("t5_done_early", 32'(done), 0);
      step(1);
      check("t5_done", 32'(done), 1);
      check("t5_left", 32'(change_left), 0);
      step(1);
      check("t5_done_pulse", 32'(done), 0);
      check("t5_idle", 32'(busy), 0);
      check("t5_no_req", 32'(coin_log.size()), 0);

      // 7 cents: not a nickel multiple, fault at once
      pulse_start(8'd7);
      check("t5_bad_amt_err", 32'(err), 1);
      check("t5_bad_amt_left", 32'(change_left), 7);
      pulse_clear();

      // reset during the second request, then a clean single dime
      new_case();
      hop_en = 1'b1;
      pulse_start(8'd40);
      n = 0;
      while (!(coin_req && coin_sel == 2'b10) && n < 100) begin
         step(1);
         n++;
      end
      check("t6_second_req", 32'(coin_sel), 2);
      clr_n = 1'b0;
      #1;
      check("t6_req_drop", 32'(coin_req), 0);
      check("t6_sel", 32'(coin_sel), 0);
      check("t6_left", 32'(change_left), 0);
      check("t6_flags", 32'({busy, done, err}), 0);
      step(2);
      clr_n = 1'b1;
      step(1);
      new_case();
      pulse_start(8'd10);
      wait_done(1, 100);
      check("t6_coins", 32'(coin_log.size()), 1);
      check("t6_dime", 32'(coin_log[0]), 2);
      step(1);
      check("t6_left_end", 32'(change_left), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish by %0t required finish earlier", $time);
      $fatal(1);
   end

endmodule
